// File: rtl/sd_spi_master.sv
// SD-card SPI master, mode 0. It shifts one byte, or a burst of bytes with
// 0xFF filler after the first, at a selectable sck half-period.
// Runs entirely on fclk. A start pulse is accepted only while idle.
module sd_spi_master #(
    parameter int SLOW_HALF = 64,
    parameter int BURST_W   = 10
) (
    input  logic               fclk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         din,
    input  logic [1:0]         speed,
    input  logic [BURST_W-1:0] burst_len,
    output logic [7:0]         dout,
    output logic               done,
    output logic               busy,
    output logic               sck,
    output logic               sdo,
    input  logic               sdi
);

    localparam int DIV_W = (SLOW_HALF > 4) ? $clog2(SLOW_HALF) : 2;

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t             state_q;
    logic [7:0]         shreg_q;
    logic [1:0]         hsel_q;
    logic [BURST_W-1:0] remain_q;
    logic [2:0]         bitcnt_q;
    logic [DIV_W-1:0]   divcnt_q;
    logic               sbit_q;
    logic [7:0]         dout_q;
    logic               done_q;
    logic               busy_q;
    logic               sck_q;
    logic               sdo_q;

    logic [DIV_W-1:0]   half_last_d;
    logic               phase_end_d;

    // Last divider count of a half-period (H-1), decoded from the latched rate.
    always_comb begin
        half_last_d = '0;
        case (hsel_q)
            2'b00:   half_last_d = DIV_W'(0);
            2'b01:   half_last_d = DIV_W'(1);
            2'b10:   half_last_d = DIV_W'(3);
            default: half_last_d = DIV_W'(SLOW_HALF - 1);
        endcase
        phase_end_d = (divcnt_q == half_last_d);
    end

    // Transfer FSM: all state and outputs are registered here.
    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            hsel_q   <= '0;
            remain_q <= '0;
            bitcnt_q <= '0;
            divcnt_q <= '0;
            sbit_q   <= 1'b0;
            dout_q   <= 8'hFF;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            sck_q    <= 1'b0;
            sdo_q    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sck_q <= 1'b0;
                    sdo_q <= 1'b1;
                    if (start) begin
                        shreg_q  <= din;
                        hsel_q   <= speed;
                        remain_q <= burst_len;
                        bitcnt_q <= '0;
                        divcnt_q <= '0;
                        sdo_q    <= din[7];
                        busy_q   <= 1'b1;
                        state_q  <= LOW;
                    end
                end
                LOW: begin
                    if (phase_end_d) begin
                        divcnt_q <= '0;
                        sck_q    <= 1'b1;
                        sbit_q   <= sdi;
                        state_q  <= HIGH;
                    end else begin
                        divcnt_q <= divcnt_q + 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_end_d) begin
                        divcnt_q <= '0;
                        sck_q    <= 1'b0;
                        shreg_q  <= {shreg_q[6:0], sbit_q};
                        if (bitcnt_q != 3'd7) begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                            sdo_q    <= shreg_q[6];
                            state_q  <= LOW;
                        end else begin
                            dout_q   <= {shreg_q[6:0], sbit_q};
                            done_q   <= 1'b1;
                            bitcnt_q <= '0;
                            sdo_q    <= 1'b1;
                            if (remain_q != '0) begin
                                // Burst continues: filler byte, no gap.
                                remain_q <= remain_q - 1'b1;
                                shreg_q  <= 8'hFF;
                                state_q  <= LOW;
                            end else begin
                                busy_q   <= 1'b0;
                                state_q  <= IDLE;
                            end
                        end
                    end else begin
                        divcnt_q <= divcnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout = dout_q;
    assign done = done_q;
    assign busy = busy_q;
    assign sck  = sck_q;
    assign sdo  = sdo_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Scoreboard bench for sd_spi_master: stimulus pushes expected bytes, done
// times and MOSI bytes; a negedge monitor models the card and checks them.
module tb_sd_spi_master;

    localparam int SLOW_HALF = 64;
    localparam int BURST_W   = 10;

    logic               fclk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         din;
    logic [1:0]         speed;
    logic [BURST_W-1:0] burst_len;
    logic [7:0]         dout;
    logic               done;
    logic               busy;
    logic               sck;
    logic               sdo;
    logic               sdi;

    always #5 fclk = ~fclk;

    sd_spi_master #(.SLOW_HALF(SLOW_HALF), .BURST_W(BURST_W)) dut (
        .fclk(fclk), .rst(rst), .start(start), .din(din), .speed(speed),
        .burst_len(burst_len), .dout(dout), .done(done), .busy(busy),
        .sck(sck), .sdo(sdo), .sdi(sdi)
    );

    int unsigned cyc = 0;
    always @(posedge fclk) cyc <= cyc + 1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        int unsigned when;
        logic [7:0]  miso;
        bit          last;
    } exp_t;

    exp_t        done_q[$];
    logic [7:0]  mosi_q[$];
    logic [7:0]  card_q[$];
    logic [7:0]  card_cur = 8'hFF;
    bit          loopback = 1'b0;
    int unsigned cbit = 0;
    int unsigned mbits = 0;
    logic [7:0]  mosi_sh = 8'h00;
    logic        sck_prev = 1'b0;
    bit          seen_fall = 1'b0;
    int unsigned t_edge = 0;
    int unsigned cur_h = 1;

    assign sdi = loopback ? sdo : card_cur[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
    endtask

    function automatic int unsigned half_of(input logic [1:0] sp);
        case (sp)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return SLOW_HALF;
        endcase
    endfunction

    // Card model and scoreboard monitor, sampled away from the active edge.
    always @(negedge fclk) begin
        if (rst) begin
            mbits = 0;
            cbit = 0;
            sck_prev = 1'b0;
            seen_fall = 1'b0;
        end else begin
            if (sck && !sck_prev) begin
                mosi_sh = {mosi_sh[6:0], sdo};
                mbits++;
                if (mbits == 8) begin
                    mbits = 0;
                    if (mosi_q.size() == 0) unexpected("mosi_byte");
                    else check("mosi_byte", mosi_sh, mosi_q.pop_front());
                end
                if (seen_fall) check("sck_low_width", cyc - t_edge, cur_h);
                t_edge = cyc;
            end
            if (!sck && sck_prev) begin
                check("sck_high_width", cyc - t_edge, cur_h);
                t_edge = cyc;
                seen_fall = 1'b1;
                card_cur = {card_cur[6:0], 1'b1};
                cbit++;
                if (cbit == 8) begin
                    cbit = 0;
                    if (card_q.size() > 0) card_cur = card_q.pop_front();
                    else card_cur = 8'hFF;
                end
            end
            sck_prev = sck;
            if (done) begin
                if (done_q.size() == 0) begin
                    unexpected("done");
                end else begin
                    exp_t e;
                    e = done_q.pop_front();
                    check("done_time", cyc, e.when);
                    check("dout", dout, e.miso);
                    check("busy_at_done", busy, !e.last);
                end
            end
        end
    end

    // Called at a negedge; pushes the reference result and pulses start.
    task automatic issue(input logic [7:0] d, input logic [1:0] sp,
                         input int unsigned bl, input bit lb);
        int unsigned h;
        int unsigned s;
        logic [7:0]  snap[$];
        exp_t        e;
        #1;
        h = half_of(sp);
        snap = card_q;
        loopback = lb;
        cbit = 0;
        seen_fall = 1'b0;
        cur_h = h;
        card_cur = 8'hFF;
        if (!lb && card_q.size() > 0) card_cur = card_q.pop_front();
        s = cyc;
        for (int unsigned i = 0; i <= bl; i++) begin
            mosi_q.push_back((i == 0) ? d : 8'hFF);
            e.when = s + 1 + 16 * h * (i + 1);
            e.last = (i == bl);
            if (lb) e.miso = (i == 0) ? d : 8'hFF;
            else    e.miso = (i < snap.size()) ? snap[i] : 8'hFF;
            done_q.push_back(e);
        end
        din = d;
        speed = sp;
        burst_len = BURST_W'(bl);
        start = 1'b1;
        @(negedge fclk);
        start = 1'b0;
        check("busy_rise", busy, 1'b1);
        din = 8'($urandom);
        speed = 2'($urandom);
        burst_len = BURST_W'($urandom);
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while ((busy || done_q.size() != 0) && n < 20000) begin
            @(negedge fclk);
            n++;
        end
        if (n >= 20000) unexpected("timeout_idle");
        @(negedge fclk);
        check("idle_sdo", sdo, 1'b1);
        check("idle_sck", sck, 1'b0);
        check("mosi_drained", mosi_q.size(), 0);
    endtask

    task automatic wait_last_done();
        int unsigned n;
        n = 0;
        do begin
            @(negedge fclk);
            n++;
        end while (!(done && !busy) && n < 20000);
        if (n >= 20000) unexpected("timeout_done");
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        din = 8'h00;
        speed = 2'b00;
        burst_len = '0;
        repeat (3) @(negedge fclk);
        check("rst_sck", sck, 1'b0);
        check("rst_sdo", sdo, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dout", dout, 8'hFF);
        rst = 1'b0;
        @(negedge fclk);

        // Single byte, loopback, fastest rate.
        issue(8'hA5, 2'b00, 0, 1'b1);
        wait_idle();

        // Init rate, card returns zeros.
        card_q = {8'h00};
        issue(8'hFF, 2'b11, 0, 1'b0);
        wait_idle();

        // Burst of four with a card response.
        card_q = {8'h12, 8'h34, 8'h56, 8'h78};
        issue(8'h51, 2'b01, 3, 1'b0);
        wait_idle();

        // A second start while busy must be ignored.
        card_q = {8'h3C};
        issue(8'hC3, 2'b00, 0, 1'b0);
        repeat (3) @(negedge fclk);
        #1;
        din = 8'h00;
        start = 1'b1;
        @(negedge fclk);
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge fclk);

        // Reset in the middle of a byte aborts with no done.
        card_q = {8'h99};
        issue(8'h6E, 2'b01, 0, 1'b0);
        begin
            int unsigned n;
            n = 0;
            while (mbits < 4 && n < 1000) begin
                @(negedge fclk);
                n++;
            end
            if (n >= 1000) unexpected("timeout_bit4");
        end
        #1;
        rst = 1'b1;
        @(negedge fclk);
        check("abort_sck", sck, 1'b0);
        check("abort_sdo", sdo, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_dout", dout, 8'hFF);
        check("abort_done", done, 1'b0);
        done_q.delete();
        mosi_q.delete();
        card_q.delete();
        #1;
        rst = 1'b0;
        repeat (20) @(negedge fclk);
        card_q = {8'h5A};
        issue(8'h81, 2'b10, 0, 1'b0);
        wait_idle();

        // Back-to-back: restart in the cycle busy is first seen low.
        card_q = {8'hDE};
        issue(8'h17, 2'b00, 0, 1'b0);
        wait_last_done();
        card_q = {8'hAD};
        issue(8'hE8, 2'b00, 0, 1'b0);
        wait_idle();

        // Randomized transfers.
        for (int unsigned k = 0; k < 10; k++) begin
            logic [1:0]  sp;
            int unsigned bl;
            bit          lb;
            sp = 2'($urandom_range(0, 2));
            bl = $urandom_range(0, 3);
            lb = 1'($urandom);
            card_q.delete();
            for (int unsigned j = 0; j <= bl; j++) card_q.push_back(8'($urandom));
            issue(8'($urandom), sp, bl, lb);
            wait_idle();
        end

        // Maximum burst length: 2^BURST_W bytes, no underflow.
        issue(8'h3B, 2'b00, (1 << BURST_W) - 1, 1'b1);
        wait_idle();
        repeat (40) @(negedge fclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
